music_sequencer: RTL and testbench

//  Parametrised melody player; successor to the fixed single-tone divider.

---
 rtl/music_sequencer.sv | 176 +++++++++++++++++
 tb/tb_music_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/music_sequencer.sv
// Melody player: walks a combinational song ROM and plays each
// (note, duration) entry as a 50%-duty square wave on the speaker pin.
module music_sequencer #(
  parameter int CLK_HZ      = 25_000_000,
  parameter int SONG_LEN    = 32,
  parameter int AW          = 5,
  parameter int BEAT_CYCLES = 3_125_000,
  parameter int GAP_CYCLES  = 250_000,
  parameter int DIV_W       = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          loop_en,
  output logic [AW-1:0] song_addr,
  input  logic [6:0]    song_data,
  output logic          speaker,
  output logic          busy,
  output logic          done
);

  localparam int DUR_W = $clog2(8 * BEAT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 2);
  localparam logic [AW-1:0] LAST = AW'(SONG_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST =
    GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_PLAY,
    S_GAP
  } state_t;

  state_t            state, state_n;
  logic [AW-1:0]     addr_n;
  logic              spk_n, busy_n, done_n;
  logic [DIV_W-1:0]  div_cnt, div_n;
  logic [DIV_W-1:0]  half, half_n;
  logic [DUR_W-1:0]  dur_cnt, dur_n;
  logic [DUR_W-1:0]  play_len, len_n;
  logic [GAP_W-1:0]  gap_cnt, gap_n;
  logic              rest, rest_n;
  logic              eon;

  // Half-period table, folded to constants at elaboration
  function automatic logic [DIV_W-1:0] half_of(input logic [3:0] n);
    case (n)
      4'd1:    half_of = DIV_W'(CLK_HZ / 524);
      4'd2:    half_of = DIV_W'(CLK_HZ / 554);
      4'd3:    half_of = DIV_W'(CLK_HZ / 588);
      4'd4:    half_of = DIV_W'(CLK_HZ / 622);
      4'd5:    half_of = DIV_W'(CLK_HZ / 660);
      4'd6:    half_of = DIV_W'(CLK_HZ / 698);
      4'd7:    half_of = DIV_W'(CLK_HZ / 740);
      4'd8:    half_of = DIV_W'(CLK_HZ / 784);
      4'd9:    half_of = DIV_W'(CLK_HZ / 830);
      4'd10:   half_of = DIV_W'(CLK_HZ / 880);
      4'd11:   half_of = DIV_W'(CLK_HZ / 932);
      4'd12:   half_of = DIV_W'(CLK_HZ / 988);
      4'd13:   half_of = DIV_W'(CLK_HZ / 1046);
      4'd14:   half_of = DIV_W'(CLK_HZ / 1174);
      4'd15:   half_of = DIV_W'(CLK_HZ / 1318);
      default: half_of = '0;
    endcase
  endfunction

  always_comb begin
    state_n = state;
    addr_n  = song_addr;
    spk_n   = 1'b0;
    done_n  = 1'b0;
    div_n   = div_cnt;
    dur_n   = dur_cnt;
    gap_n   = gap_cnt;
    len_n   = play_len;
    half_n  = half;
    rest_n  = rest;
    eon     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_FETCH;
          addr_n  = '0;
        end
      end
      S_FETCH: begin
        len_n   = DUR_W'(BEAT_CYCLES) *
                  (DUR_W'(song_data[6:4]) + DUR_W'(1));
        half_n  = half_of(song_data[3:0]);
        rest_n  = (song_data[3:0] == 4'd0);
        div_n   = '0;
        dur_n   = '0;
        state_n = S_PLAY;
      end
      S_PLAY: begin
        if (dur_cnt == play_len - DUR_W'(1)) begin
          if (GAP_CYCLES == 0) begin
            eon = 1'b1;
          end else begin
            state_n = S_GAP;
            gap_n   = '0;
          end
        end else begin
          dur_n = dur_cnt + DUR_W'(1);
          spk_n = speaker;
          if (!rest) begin
            if (div_cnt == half - DIV_W'(1)) begin
              div_n = '0;
              spk_n = ~speaker;
            end else begin
              div_n = div_cnt + DIV_W'(1);
            end
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) eon = 1'b1;
        else gap_n = gap_cnt + GAP_W'(1);
      end
    endcase

    if (eon) begin
      if (song_addr != LAST) begin
        addr_n  = song_addr + AW'(1);
        state_n = S_FETCH;
      end else if (loop_en) begin
        addr_n  = '0;
        state_n = S_FETCH;
      end else begin
        addr_n  = '0;
        state_n = S_IDLE;
        done_n  = 1'b1;
      end
    end

    // Abort beats every other request, including a same-cycle start
    if (stop) begin
      state_n = S_IDLE;
      addr_n  = '0;
      spk_n   = 1'b0;
      done_n  = 1'b0;
    end
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      song_addr <= '0;
      speaker   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_cnt   <= '0;
      dur_cnt   <= '0;
      gap_cnt   <= '0;
      play_len  <= '0;
      half      <= '0;
      rest      <= 1'b0;
    end else begin
      state     <= state_n;
      song_addr <= addr_n;
      speaker   <= spk_n;
      busy      <= busy_n;
      done      <= done_n;
      div_cnt   <= div_n;
      dur_cnt   <= dur_n;
      gap_cnt   <= gap_n;
      play_len  <= len_n;
      half      <= half_n;
      rest      <= rest_n;
    end
  end

endmodule

// File: tb/tb_music_sequencer.sv
// Randomised bench for music_sequencer against a timeline model
// built from note frequencies and beat/gap lengths.
module tb_music_sequencer;

  localparam int CLK_HZ = 26_400;
  localparam int LEN    = 4;
  localparam int BEAT   = 100;
  localparam int GAPC   = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, loop_en;
  logic [1:0] song_addr;
  logic [6:0] song_data;
  logic       speaker, busy, done;

  logic [6:0] rom [LEN];
  int freq [16] = '{0, 262, 277, 294, 311, 330, 349, 370,
                    392, 415, 440, 466, 494, 523, 587, 659};

  int n_chk  = 0;
  int n_fail = 0;

  assign song_data = rom[song_addr];

  always #5 clk = ~clk;

  music_sequencer #(
    .CLK_HZ(CLK_HZ), .SONG_LEN(LEN), .AW(2),
    .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAPC), .DIV_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .loop_en(loop_en), .song_addr(song_addr),
    .song_data(song_data), .speaker(speaker),
    .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({speaker, busy, done, song_addr});
  endfunction

  // Expected {speaker,busy,done,addr} t cycles after the start edge
  function automatic logic [31:0] model(input int t, input bit lp);
    int pos, i, n, d, play, k, hp;
    logic spk;
    pos = t - 1;
    i   = 0;
    for (int g = 0; g < 10000; g++) begin
      n    = int'(rom[i][3:0]);
      d    = int'(rom[i][6:4]);
      play = (d + 1) * BEAT;
      if (pos < play + GAPC + 1) begin
        k = pos - 1;
        if (pos == 0 || k >= play || n == 0) begin
          spk = 1'b0;
        end else begin
          hp  = CLK_HZ / (2 * freq[n]);
          spk = ((k / hp) % 2) == 1;
        end
        return 32'({spk, 1'b1, 1'b0, 2'(i)});
      end
      pos -= play + GAPC + 1;
      i++;
      if (i == LEN) begin
        if (!lp) return (pos == 0) ? 32'b00100 : 32'b0;
        i = 0;
      end
    end
    return 32'b0;
  endfunction

  function automatic int song_cycles();
    int s = 0;
    for (int i = 0; i < LEN; i++)
      s += (int'(rom[i][6:4]) + 1) * BEAT + GAPC + 1;
    return s;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input bit lp, input int ncyc,
                     input int stop_at, input int restart_at);
    int f0;
    logic [31:0] e;
    f0      = n_fail;
    loop_en = lp;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int t = 1; t <= ncyc; t++) begin
      e = (stop_at > 0 && t > stop_at) ? 32'b0 : model(t, lp);
      check(tag, outs(), e);
      if (n_fail != f0) break;
      start = (t == restart_at);
      stop  = (t == stop_at);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    stop  = 1'b0;
    if (n_fail != f0) do_reset();
  endtask

  task automatic rand_rom();
    for (int i = 0; i < LEN; i++)
      rom[i] = {3'($urandom_range(0, 2)), 4'($urandom)};
  endtask

  initial begin
    int sa;
    bit lp;
    rst_n   = 1'b0;
    start   = 1'b0;
    stop    = 1'b0;
    loop_en = 1'b0;
    for (int i = 0; i < LEN; i++) rom[i] = 7'h0a;
    #1;
    check("reset", outs(), 32'b0);
    #21;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle", outs(), 32'b0);

    // A4, rest x3 beats, E5 x8 beats, C4
    rom[0] = {3'd0, 4'd10};
    rom[1] = {3'd2, 4'd0};
    rom[2] = {3'd7, 4'd15};
    rom[3] = {3'd0, 4'd1};
    run("song_a", 1'b0, song_cycles() + 5, 0, 0);

    // Four 1-beat notes, a stray start mid-song
    for (int i = 0; i < LEN; i++) rom[i] = {3'd0, 4'($urandom_range(1, 15))};
    run("one_pass", 1'b0, song_cycles() + 5, 0, 150);
    run("looped", 1'b1, 1000, 990, 500);

    // Stop on the 50th PLAY cycle of entry 0
    run("stop", 1'b0, 60, 51, 0);

    start = 1'b1;
    stop  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("start_stop", outs(), 32'b0);
      @(posedge clk);
      #1;
    end

    for (int r = 0; r < 4; r++) begin
      rand_rom();
      lp = 1'($urandom);
      if (lp) begin
        sa = $urandom_range(200, 900);
        run("rand_loop", 1'b1, sa + 5, sa, sa / 2);
      end else begin
        run("rand_once", 1'b0, song_cycles() + 5, 0, 0);
      end
    end

    // Async reset in the middle of a high phase
    rom[0] = {3'd0, 4'd10};
    loop_en = 1'b0;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    check("pre_rst", outs(), model(40, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", outs(), 32'b0);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("post_rst", outs(), 32'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
